// File: rtl/wb_pkg.sv
// Shared types and constants for the scalar register-file write-back arbiter.
package wb_pkg;

  localparam int WB_DATA_W = 36;
  localparam int WB_REG_W  = 5;
  localparam int WB_NREQ   = 3;

  localparam int WB_LOAD = 0;
  localparam int WB_ALU  = 1;
  localparam int WB_LONG = 2;

  // 'reg' is a keyword, so the destination index field is named dst.
  typedef struct packed {
    logic [WB_REG_W-1:0]  dst;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [WB_NREQ-1:0] lowest_one_hot(input logic [WB_NREQ-1:0] mask);
    return mask & (~mask + 1'b1);
  endfunction

endpackage

// File: rtl/scalar_wb_arbiter_if.sv
// Write-back request/grant bundle between result producers and the arbiter.
interface scalar_wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_W  = WB_REG_W
);
  logic [WB_NREQ-1:0]             req_valid;
  logic [WB_NREQ-1:0][REG_W-1:0]  req_reg;
  logic [WB_NREQ-1:0][DATA_W-1:0] req_data;
  logic [WB_NREQ-1:0]             req_ready;
  logic                           hold;
  logic                           rf_wr_en;
  logic [REG_W-1:0]               rf_wr_reg;
  logic [DATA_W-1:0]              rf_wr_data;
  logic                           wb_conflict;

  // Producer side (pipeline stages / bench).
  modport master (
    output req_valid, req_reg, req_data, hold,
    input  req_ready, rf_wr_en, rf_wr_reg, rf_wr_data, wb_conflict
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_reg, req_data, hold,
    output req_ready, rf_wr_en, rf_wr_reg, rf_wr_data, wb_conflict
  );
endinterface

// File: rtl/wb_age_counter.sv
// Per-requester wait counter; flags a requester that has waited LIMIT cycles.
module wb_age_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic granted,
  output logic starved
);
  logic [3:0] age_reg;

  // Hold cycles are not special here: a valid, ungranted requester is waiting.
  always_ff @(posedge clk) begin
    if (rst || !valid || granted) begin
      age_reg <= '0;
    end else if (age_reg != 4'(LIMIT)) begin
      age_reg <= age_reg + 4'd1;
    end
  end

  assign starved = (age_reg == 4'(LIMIT));
endmodule

// File: rtl/scalar_wb_arbiter.sv
// Fixed-priority write-back arbiter with aging override and a registered
// register-file write port.
module scalar_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W       = WB_DATA_W,
  parameter int REG_W        = WB_REG_W,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst,
  scalar_wb_arbiter_if.slave bus
);
  logic [WB_NREQ-1:0] starved;
  logic [WB_NREQ-1:0] starved_req;
  logic [WB_NREQ-1:0] grant;
  logic [REG_W-1:0]   sel_reg;
  logic [DATA_W-1:0]  sel_data;
  logic               conflict_next;

  logic               wr_en_reg;
  logic [REG_W-1:0]   wr_reg_reg;
  logic [DATA_W-1:0]  wr_data_reg;
  logic               conflict_reg;

  generate
    for (genvar gi = 0; gi < WB_NREQ; gi++) begin : g_age
      wb_age_counter #(.LIMIT(STARVE_LIMIT)) u_age (
        .clk     (clk),
        .rst     (rst),
        .valid   (bus.req_valid[gi]),
        .granted (grant[gi]),
        .starved (starved[gi])
      );
    end
  endgenerate

  always_comb begin
    grant       = '0;
    starved_req = bus.req_valid & starved;
    if (!rst && !bus.hold) begin
      grant = (|starved_req) ? lowest_one_hot(starved_req)
                             : lowest_one_hot(bus.req_valid);
    end
  end

  assign bus.req_ready = grant;

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < WB_NREQ; i++) begin
      if (grant[i]) begin
        sel_reg  = bus.req_reg[i];
        sel_data = bus.req_data[i];
      end
    end
  end

  assign conflict_next = ($countones(bus.req_valid) >= 2);

  // An r0 grant consumes the requester but leaves the write port untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_reg    <= 1'b0;
      wr_reg_reg   <= '0;
      wr_data_reg  <= '0;
      conflict_reg <= 1'b0;
    end else begin
      conflict_reg <= conflict_next;
      wr_en_reg    <= (|grant) && (sel_reg != '0);
      if ((|grant) && (sel_reg != '0)) begin
        wr_reg_reg  <= sel_reg;
        wr_data_reg <= sel_data;
      end
    end
  end

  assign bus.rf_wr_en    = wr_en_reg;
  assign bus.rf_wr_reg   = wr_reg_reg;
  assign bus.rf_wr_data  = wr_data_reg;
  assign bus.wb_conflict = conflict_reg;
endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed self-checking bench for scalar_wb_arbiter.
module tb_scalar_wb_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  scalar_wb_arbiter_if bus ();

  scalar_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input wb_req_t r);
    bus.req_valid[i] = v;
    bus.req_reg[i]   = r.dst;
    bus.req_data[i]  = r.data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(WB_LOAD, 1'b1, '{dst: 5'd1, data: 36'h11});
    set_req(WB_ALU,  1'b1, '{dst: 5'd2, data: 36'h22});
    set_req(WB_LONG, 1'b1, '{dst: 5'd4, data: 36'h44});
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus.req_ready !== 3'b000) begin
        errors++; $display("FAIL reset_ready c%0d: got %b expected 000", c, bus.req_ready);
      end
      step();
      checks++;
      if (bus.rf_wr_en !== 1'b0 || bus.rf_wr_reg !== 5'd0 || bus.rf_wr_data !== 36'h0 || bus.wb_conflict !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs c%0d: got en=%b reg=%0d data=%h conf=%b expected 0/0/0/0",
                 c, bus.rf_wr_en, bus.rf_wr_reg, bus.rf_wr_data, bus.wb_conflict);
      end
    end
    rst = 1'b0;
    bus.req_valid = '0;
    $display("reset: held 2 cycles with all requesters valid");
  endtask

  task automatic test_single_alu();
    set_req(WB_ALU, 1'b1, '{dst: 5'd3, data: 36'hAB});
    #1;
    checks++;
    if (bus.req_ready !== 3'b010) begin
      errors++; $display("FAIL single_ready: got %b expected 010", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    checks++;
    if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_reg !== 5'd3 || bus.rf_wr_data !== 36'h0000000AB) begin
      errors++;
      $display("FAIL single_write: got en=%b reg=%0d data=%h expected 1/3/0000000ab",
               bus.rf_wr_en, bus.rf_wr_reg, bus.rf_wr_data);
    end
    $display("single alu: r3 <= %h", bus.rf_wr_data);
  endtask

  task automatic test_collision();
    logic [2:0]  exp_ready [3];
    logic [4:0]  exp_reg   [3];
    logic [35:0] exp_data  [3];
    logic        exp_conf  [3];
    exp_ready = '{3'b001, 3'b010, 3'b100};
    exp_reg   = '{5'd1, 5'd2, 5'd4};
    exp_data  = '{36'h11, 36'h22, 36'h44};
    exp_conf  = '{1'b1, 1'b1, 1'b0};
    set_req(WB_LOAD, 1'b1, '{dst: 5'd1, data: 36'h11});
    set_req(WB_ALU,  1'b1, '{dst: 5'd2, data: 36'h22});
    set_req(WB_LONG, 1'b1, '{dst: 5'd4, data: 36'h44});
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bus.req_ready !== exp_ready[k]) begin
        errors++; $display("FAIL collision_ready%0d: got %b expected %b", k, bus.req_ready, exp_ready[k]);
      end
      step();
      bus.req_valid[k] = 1'b0;
      checks++;
      if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_reg !== exp_reg[k] || bus.rf_wr_data !== exp_data[k]) begin
        errors++;
        $display("FAIL collision_write%0d: got en=%b reg=%0d data=%h expected 1/%0d/%h",
                 k, bus.rf_wr_en, bus.rf_wr_reg, bus.rf_wr_data, exp_reg[k], exp_data[k]);
      end
      checks++;
      if (bus.wb_conflict !== exp_conf[k]) begin
        errors++; $display("FAIL collision_conflict%0d: got %b expected %b", k, bus.wb_conflict, exp_conf[k]);
      end
      $display("collision: r%0d <= %h conflict=%b", bus.rf_wr_reg, bus.rf_wr_data, bus.wb_conflict);
    end
  endtask

  task automatic test_starvation();
    set_req(WB_LOAD, 1'b1, '{dst: 5'd5, data: 36'h100});
    set_req(WB_LONG, 1'b1, '{dst: 5'd6, data: 36'h66});
    for (int k = 0; k < 4; k++) begin
      bus.req_data[WB_LOAD] = 36'h100 + 36'(k);
      #1;
      checks++;
      if (bus.req_ready !== 3'b001) begin
        errors++; $display("FAIL starve_load_ready%0d: got %b expected 001", k, bus.req_ready);
      end
      step();
      checks++;
      if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_reg !== 5'd5 || bus.rf_wr_data !== 36'h100 + 36'(k)) begin
        errors++;
        $display("FAIL starve_load_write%0d: got en=%b reg=%0d data=%h expected 1/5/%h",
                 k, bus.rf_wr_en, bus.rf_wr_reg, bus.rf_wr_data, 36'h100 + 36'(k));
      end
      $display("starvation: load r5 <= %h", bus.rf_wr_data);
    end
    bus.req_data[WB_LOAD] = 36'h104;
    #1;
    checks++;
    if (bus.req_ready !== 3'b100) begin
      errors++; $display("FAIL starve_long_ready: got %b expected 100", bus.req_ready);
    end
    step();
    bus.req_valid[WB_LONG] = 1'b0;
    checks++;
    if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_reg !== 5'd6 || bus.rf_wr_data !== 36'h66) begin
      errors++;
      $display("FAIL starve_long_write: got en=%b reg=%0d data=%h expected 1/6/66",
               bus.rf_wr_en, bus.rf_wr_reg, bus.rf_wr_data);
    end
    $display("starvation: long r6 <= %h", bus.rf_wr_data);
    #1;
    checks++;
    if (bus.req_ready !== 3'b001) begin
      errors++; $display("FAIL starve_load_resume: got %b expected 001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    checks++;
    if (bus.rf_wr_reg !== 5'd5 || bus.rf_wr_data !== 36'h104) begin
      errors++;
      $display("FAIL starve_load_resume_write: got reg=%0d data=%h expected 5/104", bus.rf_wr_reg, bus.rf_wr_data);
    end
    $display("starvation: load r5 <= %h", bus.rf_wr_data);
  endtask

  task automatic test_r0();
    set_req(WB_ALU, 1'b1, '{dst: 5'd0, data: 36'hFFF});
    #1;
    checks++;
    if (bus.req_ready !== 3'b010) begin
      errors++; $display("FAIL r0_ready: got %b expected 010", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    checks++;
    if (bus.rf_wr_en !== 1'b0 || bus.rf_wr_data !== 36'h104) begin
      errors++;
      $display("FAIL r0_write: got en=%b data=%h expected 0/104", bus.rf_wr_en, bus.rf_wr_data);
    end
    $display("r0: write suppressed, data stays %h", bus.rf_wr_data);
  endtask

  task automatic test_hold();
    bus.hold = 1'b1;
    set_req(WB_LOAD, 1'b1, '{dst: 5'd7, data: 36'h77});
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.req_ready !== 3'b000) begin
        errors++; $display("FAIL hold_ready%0d: got %b expected 000", c, bus.req_ready);
      end
      step();
      checks++;
      if (bus.rf_wr_en !== 1'b0) begin
        errors++; $display("FAIL hold_wr_en%0d: got %b expected 0", c, bus.rf_wr_en);
      end
    end
    bus.hold = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 3'b001) begin
      errors++; $display("FAIL hold_release_ready: got %b expected 001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    checks++;
    if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_reg !== 5'd7 || bus.rf_wr_data !== 36'h77) begin
      errors++;
      $display("FAIL hold_release_write: got en=%b reg=%0d data=%h expected 1/7/77",
               bus.rf_wr_en, bus.rf_wr_reg, bus.rf_wr_data);
    end
    $display("hold: load r7 <= %h after release", bus.rf_wr_data);
  endtask

  task automatic test_back_to_back();
    set_req(WB_ALU, 1'b1, '{dst: 5'd9, data: 36'hA1});
    #1;
    checks++;
    if (bus.req_ready !== 3'b010) begin
      errors++; $display("FAIL b2b_ready0: got %b expected 010", bus.req_ready);
    end
    step();
    bus.req_data[WB_ALU] = 36'hA2;
    #1;
    checks++;
    if (bus.req_ready !== 3'b010) begin
      errors++; $display("FAIL b2b_ready1: got %b expected 010", bus.req_ready);
    end
    checks++;
    if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_reg !== 5'd9 || bus.rf_wr_data !== 36'hA1) begin
      errors++;
      $display("FAIL b2b_write0: got en=%b reg=%0d data=%h expected 1/9/a1", bus.rf_wr_en, bus.rf_wr_reg, bus.rf_wr_data);
    end
    $display("back-to-back: r9 <= %h", bus.rf_wr_data);
    step();
    bus.req_valid = '0;
    checks++;
    if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_data !== 36'hA2) begin
      errors++; $display("FAIL b2b_write1: got en=%b data=%h expected 1/a2", bus.rf_wr_en, bus.rf_wr_data);
    end
    $display("back-to-back: r9 <= %h", bus.rf_wr_data);
    step();
    checks++;
    if (bus.rf_wr_en !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got %b expected 0", bus.rf_wr_en);
    end
  endtask

  task automatic test_reset_mid();
    set_req(WB_LOAD, 1'b1, '{dst: 5'd8, data: 36'h88});
    rst = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 3'b000) begin
      errors++; $display("FAIL midrst_ready: got %b expected 000", bus.req_ready);
    end
    step();
    rst = 1'b0;
    checks++;
    if (bus.rf_wr_en !== 1'b0 || bus.rf_wr_reg !== 5'd0 || bus.rf_wr_data !== 36'h0) begin
      errors++;
      $display("FAIL midrst_outputs: got en=%b reg=%0d data=%h expected 0/0/0", bus.rf_wr_en, bus.rf_wr_reg, bus.rf_wr_data);
    end
    #1;
    checks++;
    if (bus.req_ready !== 3'b001) begin
      errors++; $display("FAIL midrst_represent_ready: got %b expected 001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    checks++;
    if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_reg !== 5'd8 || bus.rf_wr_data !== 36'h88) begin
      errors++;
      $display("FAIL midrst_represent_write: got en=%b reg=%0d data=%h expected 1/8/88",
               bus.rf_wr_en, bus.rf_wr_reg, bus.rf_wr_data);
    end
    $display("mid reset: load r8 <= %h after re-present", bus.rf_wr_data);
  endtask

  initial begin
    rst           = 1'b1;
    bus.hold      = 1'b0;
    bus.req_valid = '0;
    bus.req_reg   = '0;
    bus.req_data  = '0;
    step();
    test_reset();
    test_single_alu();
    test_collision();
    test_starvation();
    test_r0();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
